// File: rtl/main_input_conditioner_pkg.sv
// Shared types for the Main input conditioner: FSM encodings, vector width
// and the registered output bundle presented to Main.
package main_input_conditioner_pkg;
  localparam int VEC_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2,
    ST_RSVD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic             vld;
    logic             busy;
    logic             done;
  } out_t;
endpackage

// File: rtl/bit_debouncer.sv
// One switch bit: 2-flop synchroniser followed by a consecutive-mismatch
// debounce counter. stable only moves after DEBOUNCE_CYCLES disagreeing cycles.
module bit_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_CNT_W        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                s1_q, s2_q, stable_q, stable_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = s2_q;
      else                   cnt_d    = DB_CNT_W'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
endmodule

// File: rtl/main_input_conditioner.sv
// Drives Main's a..d: debounced switches in IDLE, an exhaustive 0000..1111
// sweep on request. All outputs come straight from flops.
module main_input_conditioner
  import main_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_CNT_W        = 5,
  parameter int SWEEP_HOLD      = 8,
  parameter int HOLD_CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VEC_W-1:0] sw_in,
  input  logic             sweep_start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             vec_valid,
  output logic             sweep_busy,
  output logic             sweep_done
);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(SWEEP_HOLD - 1);

  logic [VEC_W-1:0]      stable;
  state_e                state_q, state_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  out_t                  out_q, out_d;

  for (genvar i = 0; i < VEC_W; i++) begin : g_db
    bit_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_CNT_W       (DB_CNT_W)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw_in[i]),
      .stable(stable[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sweep_start) state_d = ST_SWEEP;
      ST_SWEEP: if (hold_q == HOLD_LAST && out_q.vec == '1) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output registers are loaded from the state being entered, so a..d and
  // the strobes line up with the first cycle of each state.
  always_comb begin
    out_d      = out_q;
    out_d.vld  = 1'b0;
    out_d.busy = 1'b0;
    out_d.done = 1'b0;
    hold_d     = '0;
    case (state_q)
      ST_SWEEP: begin
        if (state_d == ST_DONE) begin
          out_d.done = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          out_d.vec  = VEC_W'(out_q.vec + 1'b1);
          out_d.vld  = 1'b1;
          out_d.busy = 1'b1;
        end else begin
          hold_d     = HOLD_CNT_W'(hold_q + 1'b1);
          out_d.busy = 1'b1;
        end
      end
      default: begin
        if (state_d == ST_SWEEP) begin
          out_d.vec  = '0;
          out_d.vld  = 1'b1;
          out_d.busy = 1'b1;
        end else begin
          out_d.vec = stable;
          out_d.vld = (stable != out_q.vec);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      hold_q <= '0;
    end else begin
      out_q  <= out_d;
      hold_q <= hold_d;
    end
  end

  assign {a, b, c, d} = out_q.vec;
  assign vec_valid    = out_q.vld;
  assign sweep_busy   = out_q.busy;
  assign sweep_done   = out_q.done;
endmodule

// File: tb/tb_main_input_conditioner.sv
// Randomised and scenario stimulus for main_input_conditioner, checked every
// cycle against a behavioural model built from history windows and sweep time.
module tb_main_input_conditioner;
  localparam int DB = 4;
  localparam int H  = 2;

  logic       clk = 1'b0;
  logic       rst_n, sweep_start;
  logic [3:0] sw_in;
  logic       a, b, c, d, vec_valid, sweep_busy, sweep_done;

  int checks = 0, failures = 0;
  int n_vld, n_busy, n_done;

  // behavioural model state
  logic [3:0] s1m, s2m, stab, mvec;
  logic [3:0] hist [DB];
  logic       mvld, mbusy, mdone;
  int         mmode, t;   // 0 idle, 1 sweeping, 2 done

  always #5 clk = ~clk;

  main_input_conditioner #(
    .DEBOUNCE_CYCLES(DB), .DB_CNT_W(5), .SWEEP_HOLD(H), .HOLD_CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .sweep_start(sweep_start),
    .a(a), .b(b), .c(c), .d(d), .vec_valid(vec_valid),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A bit's stable value flips once the last DB synchronised samples all
  // disagree with it; the sweep is a pure function of elapsed sweep time.
  task automatic model_edge();
    logic [3:0] old_stab;
    bit         all_diff;
    if (!rst_n) begin
      s1m = 0; s2m = 0; stab = 0; mvec = 0;
      for (int i = 0; i < DB; i++) hist[i] = 0;
      mvld = 0; mbusy = 0; mdone = 0; mmode = 0; t = 0;
      return;
    end
    old_stab = stab;
    for (int i = 0; i < DB-1; i++) hist[i] = hist[i+1];
    hist[DB-1] = s2m;
    for (int bb = 0; bb < 4; bb++) begin
      all_diff = 1;
      for (int i = 0; i < DB; i++) if (hist[i][bb] == stab[bb]) all_diff = 0;
      if (all_diff) stab[bb] = ~stab[bb];
    end
    s2m = s1m;
    s1m = sw_in;
    mvld = 0; mdone = 0;
    if (mmode == 1) begin
      t++;
      if (t == 16*H) begin
        mmode = 2; mbusy = 0; mdone = 1;
      end else begin
        mvec = 4'(t / H);
        mvld = (t % H == 0);
      end
    end else if (mmode == 0 && sweep_start) begin
      mmode = 1; t = 0; mvec = 0; mvld = 1; mbusy = 1;
    end else begin
      mmode = 0;
      mvld  = (old_stab != mvec);
      mvec  = old_stab;
    end
  endtask

  task automatic step(input logic [3:0] sw, input logic ss, input logic rn);
    sw_in = sw; sweep_start = ss; rst_n = rn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("vec",  {28'd0, a, b, c, d}, {28'd0, mvec});
    chk("vld",  32'(vec_valid),  32'(mvld));
    chk("busy", 32'(sweep_busy), 32'(mbusy));
    chk("done", 32'(sweep_done), 32'(mdone));
    n_vld  += int'(vec_valid);
    n_busy += int'(sweep_busy);
    n_done += int'(sweep_done);
  endtask

  task automatic clr_cnt();
    n_vld = 0; n_busy = 0; n_done = 0;
  endtask

  initial begin
    int n;
    logic [3:0] sw;
    clr_cnt();
    // reset with switches high, then release and time the first pulse
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0);
    chk("rst_vec", {28'd0, a, b, c, d}, 32'd0);
    chk("rst_flags", {29'd0, vec_valid, sweep_busy, sweep_done}, 32'd0);
    n = 0;
    clr_cnt();
    for (int i = 0; i < 20 && !vec_valid; i++) begin
      step(4'hF, 1'b0, 1'b1);
      n++;
    end
    chk("rst_lat", 32'(n), 32'd7);
    chk("rst_vecF", {28'd0, a, b, c, d}, 32'hF);
    chk("rst_pulses", 32'(n_vld), 32'd1);

    // glitch rejection, then switch latency
    for (int i = 0; i < 12; i++) step(4'h0, 1'b0, 1'b1);
    clr_cnt();
    for (int i = 0; i < 3; i++) step(4'h8, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(4'h0, 1'b0, 1'b1);
    chk("glitch_vld", 32'(n_vld), 32'd0);
    chk("glitch_a", 32'(a), 32'd0);
    n = 0;
    for (int i = 0; i < 20 && !a; i++) begin
      step(4'h8, 1'b0, 1'b1);
      n++;
    end
    chk("sw_lat", 32'(n), 32'd7);

    // full sweep with switches at 1111: no exit pulse
    for (int i = 0; i < 12; i++) step(4'hF, 1'b0, 1'b1);
    clr_cnt();
    step(4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(4'hF, 1'b0, 1'b1);
    chk("sweep_vld", 32'(n_vld), 32'd16);
    chk("sweep_busy", 32'(n_busy), 32'd32);
    chk("sweep_done", 32'(n_done), 32'd1);

    // sweep with switches moved to 0101 underneath: one exit pulse
    clr_cnt();
    step(4'h5, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(4'h5, 1'b0, 1'b1);
    chk("exit_vld", 32'(n_vld), 32'd17);
    chk("exit_vec", {28'd0, a, b, c, d}, 32'h5);

    // reset mid-sweep at vector 0110
    step(4'h5, 1'b1, 1'b1);
    for (int i = 0; i < 40 && {a, b, c, d} != 4'h6; i++) step(4'h5, 1'b0, 1'b1);
    chk("mid_vec6", {28'd0, a, b, c, d}, 32'h6);
    clr_cnt();
    step(4'h5, 1'b0, 1'b0);
    chk("mid_rst", {26'd0, a, b, c, d, sweep_busy, sweep_done}, 32'd0);
    for (int i = 0; i < 40; i++) step(4'h5, 1'b0, 1'b1);
    chk("mid_nodone", 32'(n_done), 32'd0);
    chk("mid_nobusy", 32'(n_busy), 32'd0);

    // sweep_start held: back-to-back sweeps
    for (int i = 0; i < 110; i++) step(4'h5, 1'b1, 1'b1);

    // random traffic
    sw = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) sw = 4'($urandom_range(0, 15));
      step(sw, $urandom_range(0, 39) == 0, $urandom_range(0, 299) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
